ram_arbiter: RTL and testbench

Shares the single program/data RAM between the CPU datapath and a DMA/port requester. Each side issues a request/acknowledge transaction. The arbiter grants one requester at a time, drives the RAM strobes (RAM_CS, RAM_OE, RAM_WE), the address and the write data, and returns read data. It sits between the controller-driven datapath and the RAM. CPU has fixed priority, with a bounded-starvation guarantee for DMA.

---
 rtl/ram_arbiter_if.sv | 45 ++++
 rtl/ram_arbiter.sv | 80 ++++++++
 tb/tb_ram_arbiter.sv | 360 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_arbiter_if.sv
// Signal bundle joining the RAM arbiter, its CPU and DMA requesters and the RAM.
// slave = arbiter side, master = requester/RAM side.
interface ram_arbiter_if #(
   parameter int ADDR_W = 7,
   parameter int DATA_W = 8
);
   logic              CPU_REQ;
   logic              CPU_WE;
   logic [ADDR_W-1:0] CPU_ADDR;
   logic [DATA_W-1:0] CPU_WDATA;
   logic              CPU_ACK;
   logic [DATA_W-1:0] CPU_RDATA;
   logic              DMA_REQ;
   logic              DMA_WE;
   logic [ADDR_W-1:0] DMA_ADDR;
   logic [DATA_W-1:0] DMA_WDATA;
   logic              DMA_ACK;
   logic [DATA_W-1:0] DMA_RDATA;
   logic              RAM_CS;
   logic              RAM_OE;
   logic              RAM_WE;
   logic [ADDR_W-1:0] RAM_ADDR;
   logic [DATA_W-1:0] RAM_WDATA;
   logic [DATA_W-1:0] RAM_RDATA;
   logic              OWNER;
   logic              BUSY;

   modport slave (
      input  CPU_REQ, CPU_WE, CPU_ADDR, CPU_WDATA,
      input  DMA_REQ, DMA_WE, DMA_ADDR, DMA_WDATA,
      input  RAM_RDATA,
      output CPU_ACK, CPU_RDATA, DMA_ACK, DMA_RDATA,
      output RAM_CS, RAM_OE, RAM_WE, RAM_ADDR, RAM_WDATA,
      output OWNER, BUSY
   );

   modport master (
      output CPU_REQ, CPU_WE, CPU_ADDR, CPU_WDATA,
      output DMA_REQ, DMA_WE, DMA_ADDR, DMA_WDATA,
      output RAM_RDATA,
      input  CPU_ACK, CPU_RDATA, DMA_ACK, DMA_RDATA,
      input  RAM_CS, RAM_OE, RAM_WE, RAM_ADDR, RAM_WDATA,
      input  OWNER, BUSY
   );
endinterface

// File: rtl/ram_arbiter.sv
// Shares one RAM between CPU (fixed priority) and DMA, with bounded DMA starvation.
// Every access runs IDLE -> ACCESS -> DONE; all outputs come from registered state.
module ram_arbiter #(
   parameter int ADDR_W    = 7,
   parameter int DATA_W    = 8,
   parameter int MAX_BURST = 4
) (
   input  logic         CLK,
   input  logic         RST_,
   ram_arbiter_if.slave bus
);
   localparam int               CNT_W     = $clog2(MAX_BURST + 1);
   localparam logic [CNT_W-1:0] BURST_LIM = CNT_W'(MAX_BURST);

   typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

   state_t            state, state_nxt;
   logic              grant, grant_dma;
   logic              we, owner;
   logic [CNT_W-1:0]  starve_cnt;
   logic [ADDR_W-1:0] ram_addr;
   logic [DATA_W-1:0] ram_wdata, cpu_rdata, dma_rdata;

   always_comb begin
      state_nxt = state;
      grant     = 1'b0;
      grant_dma = 1'b0;
      case (state)
         IDLE: begin
            if (bus.CPU_REQ || bus.DMA_REQ) begin
               grant     = 1'b1;
               // DMA wins only when alone or once the CPU has used up its burst
               grant_dma = bus.DMA_REQ && (!bus.CPU_REQ || starve_cnt == BURST_LIM);
               state_nxt = ACCESS;
            end
         end
         ACCESS:  state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (!RST_) begin
         state      <= IDLE;
         starve_cnt <= '0;
         we         <= 1'b0;
         owner      <= 1'b0;
         ram_addr   <= '0;
         ram_wdata  <= '0;
         cpu_rdata  <= '0;
         dma_rdata  <= '0;
      end else begin
         state <= state_nxt;
         if (grant) begin
            owner      <= grant_dma;
            we         <= grant_dma ? bus.DMA_WE    : bus.CPU_WE;
            ram_addr   <= grant_dma ? bus.DMA_ADDR  : bus.CPU_ADDR;
            ram_wdata  <= grant_dma ? bus.DMA_WDATA : bus.CPU_WDATA;
            starve_cnt <= (!grant_dma && bus.DMA_REQ) ? starve_cnt + CNT_W'(1) : '0;
         end
         if (state == ACCESS && !we) begin
            if (owner) dma_rdata <= bus.RAM_RDATA;
            else       cpu_rdata <= bus.RAM_RDATA;
         end
      end
   end

   assign bus.RAM_CS    = (state == ACCESS);
   assign bus.RAM_OE    = (state == ACCESS) && !we;
   assign bus.RAM_WE    = (state == ACCESS) && we;
   assign bus.RAM_ADDR  = ram_addr;
   assign bus.RAM_WDATA = ram_wdata;
   assign bus.CPU_ACK   = (state == DONE) && !owner;
   assign bus.DMA_ACK   = (state == DONE) && owner;
   assign bus.CPU_RDATA = cpu_rdata;
   assign bus.DMA_RDATA = dma_rdata;
   assign bus.OWNER     = owner;
   assign bus.BUSY      = (state != IDLE);
endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: directed scenarios plus random traffic against a
// transaction-level model (grant rule, latency, reference memory).
module tb_ram_arbiter;
   localparam int ADDR_W    = 7;
   localparam int DATA_W    = 8;
   localparam int MAX_BURST = 4;
   localparam int DEPTH     = 2 ** ADDR_W;

   logic CLK  = 1'b0;
   logic RST_ = 1'b0;
   always #5 CLK = ~CLK;

   ram_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus();

   ram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_BURST(MAX_BURST)) dut (
      .CLK (CLK),
      .RST_(RST_),
      .bus (bus)
   );

   // RAM environment: combinational read, write on the edge while CS & WE
   logic [DATA_W-1:0] mem [DEPTH];
   logic              bd_we = 1'b0;
   logic [ADDR_W-1:0] bd_addr = '0;
   logic [DATA_W-1:0] bd_data = '0;
   always @(posedge CLK) begin
      if (bd_we) mem[bd_addr] <= bd_data;
      else if (bus.RAM_CS && bus.RAM_WE) mem[bus.RAM_ADDR] <= bus.RAM_WDATA;
   end
   assign bus.RAM_RDATA = (bus.RAM_CS && bus.RAM_OE) ? mem[bus.RAM_ADDR] : '0;

   // reference model
   logic [DATA_W-1:0] ref_mem [DEPTH];
   int                m_age;       // cycles since the grant edge, 0 = no access
   logic              m_owner, m_we;
   logic [ADDR_W-1:0] m_addr;
   logic [DATA_W-1:0] m_wdata, m_cpu_rd, m_dma_rd;
   int                m_starve;
   int                n_vec = 0;
   int                n_err = 0;

   task automatic model_edge();
      logic dma_wins;
      if (!RST_) begin
         if (m_age == 1 && m_we) ref_mem[m_addr] = m_wdata;  // RAM still saw the strobe
         m_age = 0; m_owner = 0; m_we = 0; m_addr = '0; m_wdata = '0;
         m_cpu_rd = '0; m_dma_rd = '0; m_starve = 0;
      end else if (m_age == 0) begin
         if (bus.CPU_REQ || bus.DMA_REQ) begin
            dma_wins = bus.DMA_REQ && (!bus.CPU_REQ || m_starve == MAX_BURST);
            m_owner  = dma_wins;
            m_we     = dma_wins ? bus.DMA_WE    : bus.CPU_WE;
            m_addr   = dma_wins ? bus.DMA_ADDR  : bus.CPU_ADDR;
            m_wdata  = dma_wins ? bus.DMA_WDATA : bus.CPU_WDATA;
            m_starve = (!dma_wins && bus.DMA_REQ) ? m_starve + 1 : 0;
            m_age    = 1;
         end
      end else if (m_age == 1) begin
         if (m_we)         ref_mem[m_addr] = m_wdata;
         else if (m_owner) m_dma_rd = ref_mem[m_addr];
         else              m_cpu_rd = ref_mem[m_addr];
         m_age = 2;
      end else begin
         m_age = 0;
      end
   endtask

   task automatic tick();
      model_edge();
      @(posedge CLK);
      @(negedge CLK);
   endtask

   task automatic set_cpu(input logic req, input logic we, input logic [ADDR_W-1:0] a,
                          input logic [DATA_W-1:0] d);
      bus.CPU_REQ = req; bus.CPU_WE = we; bus.CPU_ADDR = a; bus.CPU_WDATA = d;
   endtask

   task automatic set_dma(input logic req, input logic we, input logic [ADDR_W-1:0] a,
                          input logic [DATA_W-1:0] d);
      bus.DMA_REQ = req; bus.DMA_WE = we; bus.DMA_ADDR = a; bus.DMA_WDATA = d;
   endtask

   // release each requester at its ACK and wait for the arbiter to go quiet
   task automatic drain();
      bit done = 0;
      for (int i = 0; i < 30 && !done; i++) begin
         if (bus.CPU_ACK) bus.CPU_REQ = 1'b0;
         if (bus.DMA_ACK) bus.DMA_REQ = 1'b0;
         if (!bus.CPU_REQ && !bus.DMA_REQ && !bus.BUSY) done = 1;
         else tick();
      end
      n_vec++;
      if (!done) begin
         n_err++;
         $display("FAIL drain_timeout: busy=%b cpu_req=%b dma_req=%b, required idle", bus.BUSY,
                  bus.CPU_REQ, bus.DMA_REQ);
      end
   endtask

   task automatic load_mem();
      RST_ = 1'b0;
      for (int a = 0; a < DEPTH; a++) begin
         bd_we   = 1'b1;
         bd_addr = ADDR_W'(a);
         bd_data = (a == 'h15) ? 8'hA5 : DATA_W'($urandom);
         ref_mem[a] = bd_data;
         @(posedge CLK);
         @(negedge CLK);
      end
      bd_we = 1'b0;
   endtask

   task automatic test_reset();
      RST_ = 1'b0;
      set_cpu(1, 0, 7'h10, 8'h00);
      set_dma(1, 0, 7'h11, 8'h00);
      tick(); tick();
      n_vec++;
      if ({bus.RAM_CS, bus.RAM_OE, bus.RAM_WE, bus.RAM_ADDR, bus.RAM_WDATA, bus.CPU_ACK,
           bus.DMA_ACK, bus.CPU_RDATA, bus.DMA_RDATA, bus.OWNER, bus.BUSY} !== '0) begin
         n_err++;
         $display("FAIL reset_outputs: cs=%b oe=%b we=%b addr=%h wd=%h acks=%b%b rd=%h/%h own=%b busy=%b, required all 0",
                  bus.RAM_CS, bus.RAM_OE, bus.RAM_WE, bus.RAM_ADDR, bus.RAM_WDATA, bus.CPU_ACK,
                  bus.DMA_ACK, bus.CPU_RDATA, bus.DMA_RDATA, bus.OWNER, bus.BUSY);
      end
      RST_ = 1'b1;
      tick();
      n_vec++;
      if ({bus.RAM_CS, bus.OWNER, bus.RAM_ADDR} !== {1'b1, 1'b0, 7'h10}) begin
         n_err++;
         $display("FAIL reset_first_grant: cs=%b owner=%b addr=%h, required 1 0 10", bus.RAM_CS,
                  bus.OWNER, bus.RAM_ADDR);
      end
      tick();
      n_vec++;
      if ({bus.CPU_ACK, bus.DMA_ACK} !== 2'b10) begin
         n_err++;
         $display("FAIL reset_first_ack: acks=%b%b, required 10", bus.CPU_ACK, bus.DMA_ACK);
      end
      bus.CPU_REQ = 1'b0;
      drain();
   endtask

   task automatic test_cpu_read();
      set_cpu(1, 0, 7'h15, 8'h00);
      tick();
      n_vec++;
      if ({bus.RAM_CS, bus.RAM_OE, bus.RAM_WE, bus.RAM_ADDR} !== {3'b110, 7'h15}) begin
         n_err++;
         $display("FAIL cpu_read_access: cs/oe/we=%b%b%b addr=%h, required 110 15", bus.RAM_CS,
                  bus.RAM_OE, bus.RAM_WE, bus.RAM_ADDR);
      end
      tick();
      n_vec++;
      if ({bus.CPU_ACK, bus.DMA_ACK, bus.CPU_RDATA, bus.OWNER, bus.RAM_CS} !== {2'b10, 8'hA5, 2'b00}) begin
         n_err++;
         $display("FAIL cpu_read_done: ack=%b%b rdata=%h owner=%b cs=%b, required 10 a5 0 0",
                  bus.CPU_ACK, bus.DMA_ACK, bus.CPU_RDATA, bus.OWNER, bus.RAM_CS);
      end
      bus.CPU_REQ = 1'b0;
      tick();
      n_vec++;
      if ({bus.BUSY, bus.CPU_ACK, bus.CPU_RDATA} !== {2'b00, 8'hA5}) begin
         n_err++;
         $display("FAIL cpu_read_hold: busy=%b ack=%b rdata=%h, required 0 0 a5", bus.BUSY,
                  bus.CPU_ACK, bus.CPU_RDATA);
      end
   endtask

   task automatic test_dma_write_cpu_read();
      set_dma(1, 1, 7'h7F, 8'h3C);
      tick();
      n_vec++;
      if ({bus.RAM_CS, bus.RAM_OE, bus.RAM_WE, bus.RAM_ADDR, bus.RAM_WDATA} !== {3'b101, 7'h7F, 8'h3C}) begin
         n_err++;
         $display("FAIL dma_write_access: cs/oe/we=%b%b%b addr=%h wd=%h, required 101 7f 3c",
                  bus.RAM_CS, bus.RAM_OE, bus.RAM_WE, bus.RAM_ADDR, bus.RAM_WDATA);
      end
      tick();
      n_vec++;
      if ({bus.RAM_WE, bus.RAM_CS, bus.DMA_ACK, bus.CPU_ACK, bus.OWNER} !== 5'b00101) begin
         n_err++;
         $display("FAIL dma_write_done: we=%b cs=%b dack=%b cack=%b owner=%b, required 0 0 1 0 1",
                  bus.RAM_WE, bus.RAM_CS, bus.DMA_ACK, bus.CPU_ACK, bus.OWNER);
      end
      bus.DMA_REQ = 1'b0;
      tick();
      set_cpu(1, 0, 7'h7F, 8'h00);
      tick(); tick();
      n_vec++;
      if ({bus.CPU_ACK, bus.CPU_RDATA, bus.DMA_RDATA} !== {1'b1, 8'h3C, m_dma_rd}) begin
         n_err++;
         $display("FAIL cpu_read_back: ack=%b rdata=%h dma_rdata=%h, required 1 3c %h", bus.CPU_ACK,
                  bus.CPU_RDATA, bus.DMA_RDATA, m_dma_rd);
      end
      bus.CPU_REQ = 1'b0;
      tick();
   endtask

   task automatic test_starvation();
      int k = 0;
      set_cpu(1, 0, ADDR_W'($urandom), 8'h00);
      set_dma(1, 0, ADDR_W'($urandom), 8'h00);
      for (int cyc = 0; cyc < 60 && k < 10; cyc++) begin
         tick();
         n_vec++;
         if (bus.CPU_ACK && bus.DMA_ACK) begin
            n_err++;
            $display("FAIL ack_overlap: both ACKs high at cycle %0d, required at most one", cyc);
         end
         if (bus.RAM_CS) begin
            n_vec++;
            if (bus.OWNER !== (k % 5 == 4) || int'(dut.starve_cnt) !== ((k % 5 == 4) ? 0 : k % 5 + 1)) begin
               n_err++;
               $display("FAIL starve_grant%0d: owner=%b starve=%0d, required %0d %0d", k, bus.OWNER,
                        dut.starve_cnt, (k % 5 == 4), (k % 5 == 4) ? 0 : k % 5 + 1);
            end
            k++;
         end
         if (bus.CPU_ACK) bus.CPU_ADDR = ADDR_W'($urandom);
         if (bus.DMA_ACK) bus.DMA_ADDR = ADDR_W'($urandom);
      end
      n_vec++;
      if (k < 10) begin
         n_err++;
         $display("FAIL starve_timeout: %0d grants seen, required 10", k);
      end
      drain();
   endtask

   task automatic test_mid_reset();
      set_cpu(1, 1, 7'h20, 8'h77);
      tick();
      n_vec++;
      if ({bus.RAM_CS, bus.RAM_WE} !== 2'b11) begin
         n_err++;
         $display("FAIL midrst_access: cs=%b we=%b, required 1 1", bus.RAM_CS, bus.RAM_WE);
      end
      RST_ = 1'b0;
      bus.CPU_REQ = 1'b0;
      tick();
      n_vec++;
      if ({bus.RAM_CS, bus.RAM_OE, bus.RAM_WE, bus.RAM_ADDR, bus.RAM_WDATA, bus.CPU_ACK,
           bus.DMA_ACK, bus.CPU_RDATA, bus.DMA_RDATA, bus.OWNER, bus.BUSY} !== '0) begin
         n_err++;
         $display("FAIL midrst_outputs: cs=%b we=%b addr=%h cack=%b own=%b busy=%b, required all 0",
                  bus.RAM_CS, bus.RAM_WE, bus.RAM_ADDR, bus.CPU_ACK, bus.OWNER, bus.BUSY);
      end
      RST_ = 1'b1;
      set_dma(1, 0, 7'h00, 8'h00);
      tick();
      n_vec++;
      if ({bus.RAM_CS, bus.RAM_OE, bus.RAM_ADDR, bus.OWNER} !== {2'b11, 7'h00, 1'b1}) begin
         n_err++;
         $display("FAIL midrst_dma_access: cs=%b oe=%b addr=%h owner=%b, required 1 1 00 1",
                  bus.RAM_CS, bus.RAM_OE, bus.RAM_ADDR, bus.OWNER);
      end
      tick();
      n_vec++;
      if ({bus.DMA_ACK, bus.DMA_RDATA} !== {1'b1, ref_mem[0]}) begin
         n_err++;
         $display("FAIL midrst_dma_done: ack=%b rdata=%h, required 1 %h", bus.DMA_ACK,
                  bus.DMA_RDATA, ref_mem[0]);
      end
      bus.DMA_REQ = 1'b0;
      tick();
   endtask

   task automatic test_dma_stream();
      int  prev = -1;
      bit  found = 0;
      set_dma(1, 0, ADDR_W'($urandom), 8'h00);
      for (int cyc = 0; cyc < 13; cyc++) begin
         tick();
         if (bus.DMA_ACK) begin
            n_vec++;
            if ((prev >= 0 && cyc - prev != 3) || int'(dut.starve_cnt) !== 0 || bus.DMA_RDATA !== m_dma_rd) begin
               n_err++;
               $display("FAIL dma_stream: ack at %0d after %0d, starve=%0d rdata=%h, required gap 3 starve 0 rdata %h",
                        cyc, prev, dut.starve_cnt, bus.DMA_RDATA, m_dma_rd);
            end
            prev = cyc;
            bus.DMA_ADDR = ADDR_W'($urandom);
         end
      end
      for (int i = 0; i < 5 && !bus.RAM_CS; i++) tick();
      set_cpu(1, 0, ADDR_W'($urandom), 8'h00);
      for (int i = 0; i < 6 && !found; i++) begin
         tick();
         if (bus.DMA_ACK) bus.DMA_ADDR = ADDR_W'($urandom);
         if (bus.RAM_CS) found = 1;
      end
      n_vec++;
      if (!found || bus.OWNER !== 1'b0) begin
         n_err++;
         $display("FAIL cpu_wins_midstream: found=%0d owner=%b, required grant to 0", found, bus.OWNER);
      end
      drain();
   endtask

   task automatic test_random();
      for (int cyc = 0; cyc < 400; cyc++) begin
         tick();
         n_vec++;
         if ({bus.RAM_CS, bus.RAM_OE, bus.RAM_WE, bus.RAM_ADDR, bus.RAM_WDATA, bus.CPU_ACK,
              bus.DMA_ACK, bus.CPU_RDATA, bus.DMA_RDATA, bus.OWNER, bus.BUSY} !==
             {m_age == 1, m_age == 1 && !m_we, m_age == 1 && m_we, m_addr, m_wdata,
              m_age == 2 && !m_owner, m_age == 2 && m_owner, m_cpu_rd, m_dma_rd, m_owner, m_age != 0}
             || int'(dut.starve_cnt) !== m_starve) begin
            n_err++;
            $display("FAIL random_cycle%0d: cs/oe/we=%b%b%b addr=%h wd=%h ack=%b%b rd=%h/%h own=%b busy=%b st=%0d, required age=%0d we=%b addr=%h wd=%h rd=%h/%h own=%b st=%0d",
                     cyc, bus.RAM_CS, bus.RAM_OE, bus.RAM_WE, bus.RAM_ADDR, bus.RAM_WDATA,
                     bus.CPU_ACK, bus.DMA_ACK, bus.CPU_RDATA, bus.DMA_RDATA, bus.OWNER, bus.BUSY,
                     dut.starve_cnt, m_age, m_we, m_addr, m_wdata, m_cpu_rd, m_dma_rd, m_owner, m_starve);
         end
         if (bus.CPU_REQ) begin
            if (bus.CPU_ACK) begin
               if ($urandom_range(1, 0) == 1) set_cpu(1, 1'($urandom), ADDR_W'($urandom), DATA_W'($urandom));
               else bus.CPU_REQ = 1'b0;
            end
         end else if ($urandom_range(3, 0) == 0) begin
            set_cpu(1, 1'($urandom), ADDR_W'($urandom), DATA_W'($urandom));
         end
         if (bus.DMA_REQ) begin
            if (bus.DMA_ACK) begin
               if ($urandom_range(1, 0) == 1) set_dma(1, 1'($urandom), ADDR_W'($urandom), DATA_W'($urandom));
               else bus.DMA_REQ = 1'b0;
            end
         end else if ($urandom_range(3, 0) == 0) begin
            set_dma(1, 1'($urandom), ADDR_W'($urandom), DATA_W'($urandom));
         end
      end
      drain();
   endtask

   initial begin
      set_cpu(0, 0, '0, '0);
      set_dma(0, 0, '0, '0);
      m_age = 0; m_owner = 0; m_we = 0; m_addr = '0; m_wdata = '0;
      m_cpu_rd = '0; m_dma_rd = '0; m_starve = 0;
      @(negedge CLK);
      load_mem();
      test_reset();
      test_cpu_read();
      test_dma_write_cpu_read();
      test_starvation();
      test_mid_reset();
      test_dma_stream();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end
endmodule
